// File: rtl/zext_rr_arbiter.sv
// N-way arbiter (fixed-priority or round-robin) feeding one registered output slot.
// The granted word is zero-extended to 32 bits and tagged with its source index.
module zext_rr_arbiter #(
    parameter int OP_BITS = 32,
    parameter int NREQ    = 4,
    parameter int SW      = (NREQ < 2) ? 1 : $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*OP_BITS-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    single,
    output logic                    out_valid,
    output logic [31:0]             out_data,
    output logic [SW-1:0]           out_src,
    input  logic                    out_ready,
    output logic [15:0]             grant_cnt
);

    logic [SW-1:0]      ptr;
    logic [SW-1:0]      sel;
    logic [SW-1:0]      ptr_next;
    logic               found;
    logic               load;
    logic               grant;
    logic [OP_BITS-1:0] sel_data;
    logic [31:0]        ext_data;
    int                 idx;

    assign load = !out_valid || out_ready;
    // Gated by reset so no strobe escapes while the output slot is being cleared.
    assign grant = load && found && reset_l;
    assign req_ready = grant ? (NREQ'(1) << sel) : '0;

    // NOTE: every combinational output gets a default before the loop, otherwise
    // paths that never match would infer latches.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = single ? k : ((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx[SW-1:0]]) begin
                found = 1'b1;
                sel   = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (SW'(i) == sel) begin
                sel_data = req_data[i*OP_BITS +: OP_BITS];
            end
        end
    end

    assign ptr_next = (int'(sel) == NREQ - 1) ? '0 : sel + SW'(1);

    generate
        if (OP_BITS == 32) begin : g_pass
            assign ext_data = sel_data;
        end else begin : g_ext
            assign ext_data = {{(32-OP_BITS){1'b0}}, sel_data};
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
            grant_cnt <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= ext_data;
            out_src   <= sel;
            ptr       <= ptr_next;
            if (grant_cnt != 16'hFFFF) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end else if (load) begin
            // Slot drained with nothing to refill: data and source are left as-is.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zext_rr_arbiter.sv
// Self-checking bench for zext_rr_arbiter: a queue-based reference model checked every
// cycle against an 8-bit/4-requester instance, plus directed points on 32- and 1-bit widths.
module tb_zext_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        single = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    wire  [3:0]  req_ready;
    wire         out_valid;
    wire  [31:0] out_data;
    wire  [1:0]  out_src;
    wire  [15:0] grant_cnt;

    logic [1:0]  v32 = '0;
    logic [63:0] d32 = '0;
    wire  [1:0]  r32;
    wire         ov32;
    wire  [31:0] o32;
    wire         s32;
    wire  [15:0] c32;

    logic [1:0]  v1 = '0;
    logic [1:0]  d1 = '0;
    wire  [1:0]  r1;
    wire         ov1;
    wire  [31:0] o1;
    wire         s1;
    wire  [15:0] c1;

    int errors = 0;
    int checks = 0;

    int          m_ptr = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_src = 0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    zext_rr_arbiter #(.OP_BITS(8), .NREQ(4)) u8 (
        .clk(clk), .reset_l(reset_l), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .single(single), .out_valid(out_valid),
        .out_data(out_data), .out_src(out_src), .out_ready(out_ready), .grant_cnt(grant_cnt)
    );

    zext_rr_arbiter #(.OP_BITS(32), .NREQ(2)) u32 (
        .clk(clk), .reset_l(reset_l), .req_valid(v32), .req_data(d32),
        .req_ready(r32), .single(single), .out_valid(ov32),
        .out_data(o32), .out_src(s32), .out_ready(1'b1), .grant_cnt(c32)
    );

    zext_rr_arbiter #(.OP_BITS(1), .NREQ(2)) u1 (
        .clk(clk), .reset_l(reset_l), .req_valid(v1), .req_data(d1),
        .req_ready(r1), .single(single), .out_valid(ov1),
        .out_data(o1), .out_src(s1), .out_ready(1'b1), .grant_cnt(c1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Candidate order from the arbitration rules, first valid one wins.
    function automatic int model_pick(logic [3:0] v, logic s, int p);
        int order[$];
        for (int k = 0; k < 4; k++) order.push_back(s ? k : (p + k) % 4);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    always @(negedge clk) begin
        int         pick;
        bit         load;
        logic [3:0] exp_rdy;
        if (!reset_l) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_src = 0; m_cnt = 0;
            check("rst_req_ready", {28'd0, req_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_data", out_data, 32'd0);
            check("rst_grant_cnt", {16'd0, grant_cnt}, 32'd0);
        end else begin
            load = !m_valid || out_ready;
            pick = load ? model_pick(req_valid, single, m_ptr) : -1;
            exp_rdy = (pick >= 0) ? 4'(1 << pick) : 4'd0;
            check("mdl_req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            check("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("mdl_out_data", out_data, m_data);
            check("mdl_out_src", {30'd0, out_src}, 32'(m_src));
            check("mdl_grant_cnt", {16'd0, grant_cnt}, 32'(m_cnt));
            if (pick >= 0) begin
                m_valid = 1'b1;
                m_data  = {24'd0, req_data[pick*8 +: 8]};
                m_src   = pick;
                m_ptr   = (pick + 1) % 4;
                if (m_cnt < 65535) m_cnt++;
            end else if (load) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_l = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold_data;
        logic [1:0]  hold_src;

        // Reset with every requester asserting: no strobe may leak out.
        req_valid = 4'hF;
        sample;
        check("reset_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        do_reset;

        // Width extremes: 32-bit pass-through and 1-bit zero extension.
        v32 = 2'b10; d32 = {32'hDEADBEEF, 32'h12345678};
        v1  = 2'b01; d1  = 2'b01;
        tick;
        v32 = '0; v1 = '0;
        sample;
        check("w32_data", o32, 32'hDEADBEEF);
        check("w32_src", {31'd0, s32}, 32'd1);
        check("w1_data", o1, 32'h00000001);
        check("w1_valid", {31'd0, ov1}, 32'd1);
        tick;

        // Round-robin, all valid, full throughput.
        do_reset;
        single = 1'b0; out_ready = 1'b1;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            sample;
            check("rr_grant", {28'd0, req_ready}, 32'(1 << (i % 4)));
            if (i > 0) check("rr_data", out_data, 32'hA0 + 32'((i - 1) % 4));
            tick;
        end
        req_valid = '0;
        tick;

        // Fixed priority with 1010: requester 1 always wins.
        do_reset;
        single = 1'b1;
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            sample;
            check("fixed_grant", {28'd0, req_ready}, 32'h2);
            tick;
        end
        req_valid = '0;
        sample;
        check("fixed_cnt", {16'd0, grant_cnt}, 32'd3);
        check("fixed_src", {30'd0, out_src}, 32'd1);
        tick;

        // Backpressure: grant 2 (ptr=2), then stall 5 cycles.
        single = 1'b0; out_ready = 1'b0; req_valid = 4'hF;
        tick;
        hold_data = out_data;
        hold_src  = out_src;
        check("stall_src", {30'd0, hold_src}, 32'd2);
        check("stall_data", hold_data, 32'h000000A2);
        for (int i = 0; i < 5; i++) begin
            sample;
            check("stall_ready", {28'd0, req_ready}, 32'd0);
            check("stall_hold_data", out_data, hold_data);
            check("stall_hold_src", {30'd0, out_src}, {30'd0, hold_src});
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            tick;
        end
        out_ready = 1'b1;
        sample;
        check("stall_resume", {28'd0, req_ready}, 32'h8);
        tick;

        // Asynchronous reset mid-stream with ptr=2.
        do_reset;
        req_valid = 4'hF;
        tick;
        tick;
        #2 reset_l = 1'b0;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_data", out_data, 32'd0);
        check("async_src", {30'd0, out_src}, 32'd0);
        check("async_ready", {28'd0, req_ready}, 32'd0);
        check("async_cnt", {16'd0, grant_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        sample;
        check("post_reset_grant", {28'd0, req_ready}, 32'h1);
        tick;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            single    = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick;
        end

        // Saturation of the transfer counter.
        do_reset;
        single = 1'b0; out_ready = 1'b1; req_valid = 4'hF;
        repeat (65540) tick;
        sample;
        check("sat_cnt", {16'd0, grant_cnt}, 32'h0000FFFF);
        repeat (10) tick;
        sample;
        check("sat_hold", {16'd0, grant_cnt}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zext_rr_arbiter.md
ZEXT_RR_ARBITER -- requirements
Module: zext_rr_arbiter

Interface
REQ-001 SHALL have parameter OP_BITS, default 32: per-requester data width, legal range 1..32.
REQ-002 SHALL have parameter NREQ, default 4: requester count, legal range 2..8.
REQ-003 SHALL have parameter SW = max(1, clog2(NREQ)): width of the source index.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on the rising edge.
REQ-005 SHALL have port reset_l, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester valid.
REQ-007 SHALL have port req_data, input, NREQ*OP_BITS: requester i occupies bits [i*OP_BITS +: OP_BITS].
REQ-008 SHALL have port req_ready, output, NREQ: one-hot or zero; the accept strobe per requester.
REQ-009 SHALL have port single, input, 1: 1 = fixed priority (lowest index wins); 0 = round-robin.
REQ-010 SHALL have port out_valid, output, 1: the output register holds data.
REQ-011 SHALL have port out_data, output, 32: the zero-extended granted word.
REQ-012 SHALL have port out_src, output, SW: index of the requester that produced out_data.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts when out_valid & out_ready.
REQ-014 SHALL have port grant_cnt, output, 16: count of accepted transfers, saturating.

Function
REQ-015 SHALL define load = !out_valid | out_ready, computed combinationally each cycle.
REQ-016 SHALL assert at most one req_ready bit per cycle, and only while load=1 and the selected requester's req_valid=1.
REQ-017 SHALL, with single=1, select the lowest index with req_valid=1.
REQ-018 SHALL, with single=0, select the first valid index scanning ptr, ptr+1, ... NREQ-1, 0, ... ptr-1, with modulo-NREQ wrap.
REQ-019 SHALL update ptr to (granted index + 1) mod NREQ on every grant in either mode; ptr SHALL NOT change when there is no grant.
REQ-020 SHALL, on a grant, register the data on the next edge: out_data[OP_BITS-1:0] = selected data, all upper bits 0, out_src = index, out_valid = 1.
REQ-021 SHALL pass the data straight through without extension logic when OP_BITS==32; no zero-width replication SHALL be elaborated.
REQ-022 SHALL, when load=1 and no requester is valid, clear out_valid on the next edge and hold out_data/out_src unchanged.
REQ-023 SHALL hold out_valid, out_data and out_src stable while out_valid=1 and out_ready=0.
REQ-024 SHALL allow a simultaneous downstream accept and new grant in the same cycle, giving full throughput of 1 word/cycle.
REQ-025 SHALL give a latency of 1 cycle from req_valid&req_ready to out_valid.
REQ-026 SHALL increment grant_cnt once per req_ready pulse and saturate at 16'hFFFF without wrapping.
REQ-027 SHALL let a change of single take effect on the same cycle's selection; ptr is retained across mode changes.
REQ-028 SHALL NOT starve any requester: with single=0 and all requesters valid, each SHALL be granted once per NREQ grants.

Reset
REQ-029 SHALL, while reset_l=0 (asynchronously), force out_valid=0, out_data=0, out_src=0, ptr=0, grant_cnt=0, and req_ready all 0.
REQ-030 SHALL discard any word held in the output register when reset asserts mid-transfer; the first grant after release SHALL use ptr=0.

Verification
REQ-031 SHALL cover: OP_BITS=8, NREQ=4, single=0, all valid, out_ready=1 -> grants 0,1,2,3,0; out_data = 32'h000000_dd for each; one word per cycle.
REQ-032 SHALL cover: single=1, req_valid=4'b1010 for 3 cycles -> requester 1 is granted every cycle and requester 3 never; grant_cnt=3.
REQ-033 SHALL cover: out_valid=1 with out_ready=0 for 5 cycles -> out_data/out_src stable and req_ready=0; the first grant follows when out_ready=1.
REQ-034 SHALL cover: OP_BITS=32, data 32'hDEADBEEF -> out_data = 32'hDEADBEEF; also OP_BITS=1, data 1 -> out_data = 32'h00000001.
REQ-035 SHALL cover: reset_l dropped mid-stream with ptr=2 -> outputs are immediately 0; after release, with all valid, requester 0 is granted first.
REQ-036 SHALL cover: grant_cnt preloaded near saturation by 65540 accepted transfers -> reads 16'hFFFF and stays there.
